capture_ctrl: RTL and testbench

//  Sequences one sample-capture burst. On start, writes cfg_len 16-bit words into an internal buffer,

---
 rtl/capture_pkg.sv | 27 ++
 rtl/capture_ctrl_sample_buf.sv | 34 +++
 rtl/capture_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// capture_pkg : shared types and constants for the capture burst sequencer
// Revision    : 1.0
// ============================================================================
package capture_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DECIM_W = 8;

    localparam logic SRC_ADC = 1'b0;
    localparam logic SRC_TP  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Burst length is legal when it is 1..2**addr_w.
    function automatic logic len_valid(input logic [31:0] len, input int addr_w);
        return (len != 32'd0) && (len <= (32'd1 << addr_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ctrl_sample_buf.sv
`default_nettype none
// ============================================================================
// sample_buf : simple dual-port sample RAM, registered read, no array reset
// Revision   : 1.0
// ============================================================================
module sample_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i_50Mhz,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i_50Mhz) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// capture_ctrl : captures one decimated sample burst into RAM, then streams it
// Revision     : 1.0
// ============================================================================
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic               clk_i_50Mhz,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               src_sel_i,
    input  logic [ADDR_W:0]    cfg_len_i,
    input  logic [DECIM_W-1:0] cfg_decim_i,
    input  logic [DATA_W-1:0]  adc_data_i,
    input  logic [DATA_W-1:0]  tp_data_i,
    output logic [DATA_W-1:0]  m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_last_o,
    output logic               busy_o,
    output logic               done_o
);

    state_t              state_q, state_d;
    logic                src_sel_q, src_sel_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DECIM_W-1:0]  decim_q, decim_d;
    logic [DECIM_W-1:0]  dc_q, dc_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic                skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_last_q, skid_last_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic                done_q, done_d;

    logic                wr_en;
    logic                rd_en;
    logic                pop;
    logic [1:0]          occ;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;

    assign wr_data = (src_sel_q == SRC_TP) ? tp_data_i : adc_data_i;
    assign pop     = m_valid_q && m_ready_i;
    // Words held or in flight: output register, skid entry, outstanding RAM read.
    assign occ     = 2'(m_valid_q) + 2'(skid_valid_q) + 2'(pend_q);

    sample_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i_50Mhz (clk_i_50Mhz),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_cnt_q[ADDR_W-1:0]),
        .wr_data_i   (wr_data),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_cnt_q[ADDR_W-1:0]),
        .rd_data_o   (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        src_sel_d    = src_sel_q;
        len_d        = len_q;
        decim_d      = decim_q;
        dc_d         = dc_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        pend_d       = 1'b0;
        pend_last_d  = pend_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;

        if ((state_q != ST_IDLE) && abort_i) begin
            state_d      = ST_IDLE;
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i && len_valid(32'(cfg_len_i), ADDR_W)) begin
                        src_sel_d = src_sel_i;
                        len_d     = cfg_len_i;
                        decim_d   = cfg_decim_i;
                        dc_d      = '0;
                        wr_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        state_d   = ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    dc_d = (dc_q == decim_q) ? '0 : dc_q + DECIM_W'(1);
                    if (dc_q == '0) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
                        if (wr_cnt_d == len_q) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Only issue a read if its data is guaranteed a slot on arrival.
                    rd_en       = (rd_cnt_q != len_q) && ((occ - 2'(pop)) < 2'd2);
                    pend_d      = rd_en;
                    pend_last_d = (rd_cnt_q == len_q - (ADDR_W+1)'(1));
                    rd_cnt_d    = rd_cnt_q + (ADDR_W+1)'(rd_en);

                    if (!m_valid_q || pop) begin
                        if (skid_valid_q) begin
                            m_valid_d    = 1'b1;
                            m_data_d     = skid_data_q;
                            m_last_d     = skid_last_q;
                            skid_valid_d = pend_q;
                            skid_data_d  = rd_data;
                            skid_last_d  = pend_last_q;
                        end else if (pend_q) begin
                            m_valid_d = 1'b1;
                            m_data_d  = rd_data;
                            m_last_d  = pend_last_q;
                        end else begin
                            m_valid_d = 1'b0;
                            m_last_d  = 1'b0;
                        end
                    end else if (pend_q) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = rd_data;
                        skid_last_d  = pend_last_q;
                    end

                    if (pop && m_last_q) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        m_valid_d    = 1'b0;
                        m_last_d     = 1'b0;
                        skid_valid_d = 1'b0;
                        pend_d       = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i_50Mhz) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            src_sel_q    <= 1'b0;
            len_q        <= '0;
            decim_q      <= '0;
            dc_q         <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_sel_q    <= src_sel_d;
            len_q        <= len_d;
            decim_q      <= decim_d;
            dc_q         <= dc_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_capture_ctrl : scoreboard bench for the capture burst sequencer
// Revision        : 1.0
// ============================================================================
module tb_capture_ctrl;
    import capture_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int DECIM_W = 8;

    logic               clk_i_50Mhz = 1'b0;
    logic               rst         = 1'b0;
    logic               start_i     = 1'b0;
    logic               abort_i     = 1'b0;
    logic               src_sel_i   = 1'b0;
    logic [ADDR_W:0]    cfg_len_i   = '0;
    logic [DECIM_W-1:0] cfg_decim_i = '0;
    logic [DATA_W-1:0]  adc_data_i  = 16'h0100;
    logic [DATA_W-1:0]  tp_data_i   = 16'd0;
    logic [DATA_W-1:0]  m_data_o;
    logic               m_valid_o;
    logic               m_ready_i   = 1'b1;
    logic               m_last_o;
    logic               busy_o;
    logic               done_o;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_cnt   = 0;
    int   word_cnt   = 0;
    int   ready_mode = 0;
    int   cyc        = 0;

    capture_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DECIM_W (DECIM_W)
    ) dut (
        .clk_i_50Mhz (clk_i_50Mhz),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .src_sel_i   (src_sel_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_decim_i (cfg_decim_i),
        .adc_data_i  (adc_data_i),
        .tp_data_i   (tp_data_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #10 clk_i_50Mhz = ~clk_i_50Mhz;

    function automatic logic [15:0] adc_of(input logic [15:0] v);
        return v * 16'd3 + 16'h0100;
    endfunction

    // Free-running sources and ready pattern, updated just after each edge.
    always @(posedge clk_i_50Mhz) begin
        #1;
        cyc        = cyc + 1;
        tp_data_i  = tp_data_i + 16'd1;
        adc_data_i = adc_of(tp_data_i);
        m_ready_i  = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk_i_50Mhz) begin
        exp_t e;
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid_o), 32'd1);
            chk("stall_data", 32'(m_data_o), 32'(prev_data));
            chk("stall_last", 32'(m_last_o), 32'(prev_last));
        end
        prev_stall = rst && !abort_i && m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        if (rst && m_valid_o && m_ready_i) begin
            word_cnt = word_cnt + 1;
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_word actual=%0h required=none", m_data_o);
            end else begin
                e = sb_q.pop_front();
                chk("word_data", 32'(m_data_o), 32'(e.data));
                chk("word_last", 32'(m_last_o), 32'(e.last));
            end
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            chk("done_sb_empty", 32'(sb_q.size()), 32'd0);
            chk("done_valid_low", 32'(m_valid_o), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk_i_50Mhz);
        #2;
    endtask

    task automatic run_burst(input logic src, input int len, input int decim);
        logic [15:0] t;
        logic [15:0] v;
        exp_t        e;
        step();
        src_sel_i   = src;
        cfg_len_i   = 11'(len);
        cfg_decim_i = 8'(decim);
        start_i     = 1'b1;
        t           = tp_data_i;
        for (int i = 0; i < len; i++) begin
            v      = t + 16'(1 + i * (decim + 1));
            e.data = (src == SRC_TP) ? v : adc_of(v);
            e.last = (i == len - 1);
            sb_q.push_back(e);
        end
        step();
        start_i     = 1'b0;
        src_sel_i   = ~src;
        cfg_len_i   = 11'd3;
        cfg_decim_i = 8'd7;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n = n + 1;
        end
        repeat (3) step();
        chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_busy_low"}, 32'(busy_o), 32'd0);
        chk({name, "_valid_low"}, 32'(m_valid_o), 32'd0);
        chk({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!m_valid_o && n < budget) begin
            step();
            n = n + 1;
        end
        chk({name, "_valid_seen"}, 32'(m_valid_o), 32'd1);
    endtask

    initial begin
        int d0;
        int w0;

        repeat (3) step();
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_last", 32'(m_last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
        rst = 1'b1;
        step();

        ready_mode = 0;
        run_burst(SRC_TP, 8, 0);
        wait_done("t1", 200);
        run_burst(SRC_TP, 8, 3);
        wait_done("t2", 300);
        run_burst(SRC_ADC, 5, 1);
        wait_done("t2adc", 200);

        ready_mode = 1;
        run_burst(SRC_TP, 16, 0);
        wait_done("t3", 300);
        ready_mode = 0;

        run_burst(SRC_TP, 1024, 0);
        wait_done("t4", 5000);
        d0 = done_cnt;
        step();
        cfg_len_i = 11'd0;
        start_i   = 1'b1;
        step();
        cfg_len_i = 11'd1025;
        step();
        start_i = 1'b0;
        repeat (3) step();
        chk("t4_badlen_busy", 32'(busy_o), 32'd0);
        chk("t4_badlen_done", 32'(done_cnt - d0), 32'd0);
        run_burst(SRC_TP, 1, 0);
        wait_done("t4_len1", 100);

        d0 = done_cnt;
        run_burst(SRC_TP, 16, 2);
        repeat (10) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t5_cap_abort_busy", 32'(busy_o), 32'd0);
        chk("t5_cap_abort_valid", 32'(m_valid_o), 32'd0);
        sb_q.delete();
        ready_mode = 1;
        run_burst(SRC_TP, 16, 0);
        wait_valid("t5_drain", 100);
        repeat (3) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t5_drn_abort_busy", 32'(busy_o), 32'd0);
        chk("t5_drn_abort_valid", 32'(m_valid_o), 32'd0);
        chk("t5_drn_abort_last", 32'(m_last_o), 32'd0);
        sb_q.delete();
        repeat (5) step();
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        step();
        cfg_len_i = 11'd4;
        start_i   = 1'b1;
        abort_i   = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("t5_abort_wins", 32'(busy_o), 32'd0);
        ready_mode = 0;
        run_burst(SRC_TP, 4, 0);
        wait_done("t5_restart", 100);

        ready_mode = 1;
        run_burst(SRC_TP, 32, 0);
        wait_valid("t6_drain", 100);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("t6_rst_valid", 32'(m_valid_o), 32'd0);
        chk("t6_rst_last", 32'(m_last_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        chk("t6_rst_data", 32'(m_data_o), 32'd0);
        step();
        rst = 1'b1;
        sb_q.delete();
        d0 = done_cnt;
        w0 = word_cnt;
        run_burst(SRC_TP, 6, 1);
        repeat (4) step();
        chk("t6_busy_mid", 32'(busy_o), 32'd1);
        cfg_len_i = 11'd9;
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        wait_done("t6", 200);
        repeat (4) step();
        chk("t6_burst_count", 32'(done_cnt - d0), 32'd1);
        chk("t6_word_count", 32'(word_cnt - w0), 32'd6);
        chk("t6_not_queued", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
